// File: rtl/pixel_sink_fb_if.sv
// Pixel stream handshake between the draw-block mux and the framebuffer sink.
//   pix_valid  : pixel present on pix_x/pix_y/pix_colour/pix_last
//   pix_ready  : sink accepts a pixel this cycle
//   pix_x      : column (8 bits)
//   pix_y      : row (7 bits)
//   pix_colour : RGB 3:3:3
//   pix_last   : final pixel of a sprite
// master = pixel producer, slave = pixel sink.
interface pixel_sink_fb_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [8:0] pix_colour;
    logic       pix_last;

    modport master (
        output pix_valid, pix_x, pix_y, pix_colour, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_colour, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/pixel_sink_fb.sv
// Framebuffer pixel sink: buffers the sprite pixel stream in a small FIFO,
// discards off-screen and colour-keyed pixels, and issues one-cycle writes
// into the SCREEN_W x SCREEN_H, 9-bit framebuffer RAM.
// Ports:
//   clk        : clock, all logic on the rising edge
//   resetn     : synchronous active-low reset
//   pix        : pixel stream (slave side of pixel_sink_fb_if)
//   fb_busy    : framebuffer port unavailable, no pop this cycle
//   fb_wren    : framebuffer write strobe, one cycle per written pixel
//   fb_addr    : y*SCREEN_W + x of the write
//   fb_data    : colour of the write
//   frame_done : one-cycle pulse after the entry carrying pix_last retires
//   idle       : FIFO empty and no write in flight
//   drop_count : saturating count of off-screen pixels discarded
module pixel_sink_fb #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter bit          KEY_EN     = 1'b1,
    parameter logic [8:0]  KEY_COLOUR = 9'b111000111
) (
    input  logic                 clk,
    input  logic                 resetn,
    pixel_sink_fb_if.slave       pix,
    input  logic                 fb_busy,
    output logic                 fb_wren,
    output logic [14:0]          fb_addr,
    output logic [8:0]           fb_data,
    output logic                 frame_done,
    output logic                 idle,
    output logic [7:0]           drop_count
);

    localparam int unsigned            DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    OCC_MAX = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]    OCC_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE = 1;

    typedef struct packed {
        logic       last;
        logic [8:0] colour;
        logic [6:0] y;
        logic [7:0] x;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   occ;

    entry_t      head;
    logic        push;
    logic        pop;
    logic        off_screen;
    logic        keyed;
    logic        do_write;
    logic [14:0] head_addr;

    // Ready is a function of registered occupancy only, so a producer may
    // look at it before deciding to raise pix_valid.
    assign pix.pix_ready = (occ < OCC_MAX) && resetn;
    assign push          = pix.pix_valid && pix.pix_ready;
    assign pop           = (occ != '0) && !fb_busy;

    assign head       = mem[rd_ptr];
    assign off_screen = ({1'b0, head.x} >= 9'(SCREEN_W)) ||
                        ({1'b0, head.y} >= 8'(SCREEN_H));
    assign keyed      = KEY_EN && (head.colour == KEY_COLOUR);
    assign head_addr  = 15'(head.y) * 15'(SCREEN_W) + 15'(head.x);
    assign do_write   = pop && !off_screen && !keyed;

    assign idle = (occ == '0) && !fb_wren;

    // NOTE: the storage array has no reset; occupancy and pointers define which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{last: pix.pix_last, colour: pix.pix_colour,
                             y: pix.pix_y, x: pix.pix_x};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            fb_wren    <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase

            fb_wren    <= do_write;
            frame_done <= pop && head.last;

            // Address and data hold their last value while fb_wren is low.
            if (do_write) begin
                fb_addr <= head_addr;
                fb_data <= head.colour;
            end

            if (pop && off_screen && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_sink_fb.sv
// Self-checking bench for pixel_sink_fb: directed scenarios followed by a
// randomized stream, checked against a queue-based model of the expected
// framebuffer writes, drop count and frame pulses.
module tb_pixel_sink_fb;

    localparam int KEY = 'h1C7;

    logic        clk;
    logic        resetn;
    logic        fb_busy;
    logic        fb_wren;
    logic [14:0] fb_addr;
    logic [8:0]  fb_data;
    logic        frame_done;
    logic        idle;
    logic [7:0]  drop_count;

    pixel_sink_fb_if pif ();

    pixel_sink_fb dut (
        .clk        (clk),
        .resetn     (resetn),
        .pix        (pif.slave),
        .fb_busy    (fb_busy),
        .fb_wren    (fb_wren),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .frame_done (frame_done),
        .idle       (idle),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  exp_drop   = 0;
    int  exp_frames = 0;

    int  total = 0;
    int  bad   = 0;

    int  cyc         = 0;
    int  wr_cnt      = 0;
    int  frame_cnt   = 0;
    int  last_wr_cyc = -1;
    int  frame_cyc   = -2;
    int  last_wr_addr = -1;
    int  first_addr  = -1;
    bit  grab_first  = 1'b0;

    bit  acc;
    int  stall_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: what the framebuffer should see for an accepted pixel.
    task automatic model_push(input int x, input int y, input int c, input bit last);
        if (x >= 160 || y >= 120) begin
            if (exp_drop < 255) exp_drop++;
        end else if (c != KEY) begin
            exp_q.push_back('{addr: y * 160 + x, data: c});
        end
        if (last) exp_frames++;
    endtask

    // Write monitor: every strobe must match the next expected write in order.
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (fb_wren === 1'b1) begin
            wr_cnt++;
            last_wr_cyc  = cyc;
            last_wr_addr = int'(fb_addr);
            if (grab_first) begin
                first_addr = int'(fb_addr);
                grab_first = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(fb_addr), 32'(w.addr));
                check("wr_data", 32'(fb_data), 32'(w.data));
            end
        end
        if (frame_done === 1'b1) begin
            frame_cnt++;
            frame_cyc = cyc;
        end
    end

    // Called at negedge+1 with inputs set; advances to the next negedge+1.
    task automatic tick();
        acc = pif.pix_valid && pif.pix_ready;
        if (acc) model_push(int'(pif.pix_x), int'(pif.pix_y), int'(pif.pix_colour), pif.pix_last);
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int c, input bit last);
        int n;
        n = 0;
        pif.pix_valid  = 1'b1;
        pif.pix_x      = 8'(x);
        pif.pix_y      = 7'(y);
        pif.pix_colour = 9'(c);
        pif.pix_last   = last;
        do begin
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        stall_cnt += n - 1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        pif.pix_valid = 1'b0;
        while (idle !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (idle !== 1'b1) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int w0;
        int f0;
        int acc_n;

        resetn         = 1'b0;
        fb_busy        = 1'b0;
        pif.pix_valid  = 1'b0;
        pif.pix_x      = '0;
        pif.pix_y      = '0;
        pif.pix_colour = '0;
        pif.pix_last   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready",      32'(pif.pix_ready), 32'd0);
        check("rst_wren",       32'(fb_wren),       32'd0);
        check("rst_addr",       32'(fb_addr),       32'd0);
        check("rst_data",       32'(fb_data),       32'd0);
        check("rst_frame_done", 32'(frame_done),    32'd0);
        check("rst_drop",       32'(drop_count),    32'd0);
        check("rst_idle",       32'(idle),          32'd1);
        resetn = 1'b1;
        #1;
        check("ready_after_rst", 32'(pif.pix_ready), 32'd1);

        // Single pixel: write appears in the second cycle after the handshake
        stall_cnt = 0;
        send(5, 3, 'h0A5, 1'b0);
        pif.pix_valid = 1'b0;
        check("single_wren_n1", 32'(fb_wren), 32'd0);
        tick();
        check("single_wren_n2", 32'(fb_wren), 32'd1);
        check("single_addr",    32'(fb_addr), 32'd485);
        check("single_data",    32'(fb_data), 32'h0A5);
        tick();
        check("single_wren_off", 32'(fb_wren), 32'd0);
        check("single_idle",     32'(idle),    32'd1);
        check("single_count",    32'(wr_cnt),  32'd1);

        // 20x20 sprite at (40,20), streamed back to back
        w0 = wr_cnt;
        f0 = frame_cnt;
        stall_cnt  = 0;
        grab_first = 1'b1;
        for (int yy = 0; yy < 20; yy++) begin
            for (int xx = 0; xx < 20; xx++) begin
                send(40 + xx, 20 + yy, (xx + yy * 20) & 'hFF, (xx == 19) && (yy == 19));
            end
        end
        drain();
        check("sprite_writes",     32'(wr_cnt - w0),    32'd400);
        check("sprite_first_addr", 32'(first_addr),     32'd3240);
        check("sprite_last_addr",  32'(last_wr_addr),   32'd6299);
        check("sprite_frames",     32'(frame_cnt - f0), 32'd1);
        check("sprite_frame_cyc",  32'(frame_cyc),      32'(last_wr_cyc));
        check("sprite_stalls",     32'(stall_cnt),      32'd0);

        // fb_busy held: FIFO fills to depth, then drains one per cycle
        w0 = wr_cnt;
        fb_busy = 1'b1;
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            pif.pix_valid  = 1'b1;
            pif.pix_x      = 8'(i);
            pif.pix_y      = 7'd50;
            pif.pix_colour = 9'(16 + i);
            pif.pix_last   = 1'b0;
            tick();
            if (acc) acc_n++;
        end
        check("busy_accepted", 32'(acc_n),           32'd8);
        check("busy_ready",    32'(pif.pix_ready),   32'd0);
        check("busy_idle",     32'(idle),            32'd0);
        check("busy_nowrite",  32'(wr_cnt - w0),     32'd0);
        pif.pix_valid = 1'b0;
        fb_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("busy_release_run", 32'(fb_wren), 32'd1);
        end
        send(8, 50, 24, 1'b0);
        send(9, 50, 25, 1'b0);
        drain();
        check("busy_total_writes", 32'(wr_cnt - w0),  32'd10);
        check("busy_last_addr",    32'(last_wr_addr), 32'd8009);

        // Off-screen boundaries and drop_count saturation
        w0 = wr_cnt;
        send(160, 0,   1, 1'b0);
        send(0,   120, 2, 1'b0);
        send(159, 119, 3, 1'b0);
        drain();
        check("edge_drop",      32'(drop_count),   32'd2);
        check("edge_writes",    32'(wr_cnt - w0),  32'd1);
        check("edge_last_addr", 32'(last_wr_addr), 32'd19199);
        for (int i = 0; i < 300; i++) send(160 + (i % 96), i % 120, 5, 1'b0);
        drain();
        check("drop_saturate", 32'(drop_count), 32'd255);

        // Colour key: no write, no count, frame_done still pulses
        w0 = wr_cnt;
        send(10, 10, KEY, 1'b0);
        drain();
        check("key_nowrite", 32'(wr_cnt - w0), 32'd0);
        check("key_drop",    32'(drop_count),  32'd255);
        f0 = frame_cnt;
        send(11, 10, KEY, 1'b1);
        drain();
        check("key_frame",    32'(frame_cnt - f0), 32'd1);
        check("key_nowrite2", 32'(wr_cnt - w0),    32'd0);

        // Reset mid-stream: five entries buffered and a write in flight
        fb_busy = 1'b1;
        for (int i = 0; i < 6; i++) send(i, 60, 64 + i, 1'b0);
        pif.pix_valid = 1'b0;
        fb_busy = 1'b0;
        tick();
        check("pre_rst_wren", 32'(fb_wren), 32'd1);
        check("pre_rst_idle", 32'(idle),    32'd0);
        resetn = 1'b0;
        exp_q.delete();
        exp_drop   = 0;
        exp_frames = frame_cnt;
        #1;
        check("midrst_ready_low", 32'(pif.pix_ready), 32'd0);
        tick();
        check("midrst_wren", 32'(fb_wren),    32'd0);
        check("midrst_idle", 32'(idle),       32'd1);
        check("midrst_drop", 32'(drop_count), 32'd0);
        resetn = 1'b1;
        #1;
        check("midrst_ready_high", 32'(pif.pix_ready), 32'd1);
        w0 = wr_cnt;
        repeat (5) tick();
        check("midrst_no_stale", 32'(wr_cnt - w0), 32'd0);
        check("midrst_idle2",    32'(idle),        32'd1);

        // Randomized stream with random backpressure
        for (int i = 0; i < 800; i++) begin
            pif.pix_valid  = ($urandom_range(0, 3) != 0);
            pif.pix_x      = 8'($urandom_range(0, 170));
            pif.pix_y      = 7'($urandom_range(0, 127));
            pif.pix_colour = ($urandom_range(0, 7) == 0) ? 9'(KEY) : 9'($urandom_range(0, 511));
            pif.pix_last   = ($urandom_range(0, 15) == 0);
            fb_busy        = ($urandom_range(0, 3) == 0);
            tick();
        end
        fb_busy = 1'b0;
        drain();
        check("rand_drop",    32'(drop_count),   32'(exp_drop));
        check("rand_frames",  32'(frame_cnt),    32'(exp_frames));
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
